// File: rtl/reg_wr_arb_pkg.sv
// reg_wr_arb_pkg: shared types and helpers for the register-bank write arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   idx_width() : index width for a given requester count (minimum 1 bit)
//   rr_first()  : round-robin search returning the winner index and a valid flag
package reg_wr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Upper bound on requester count supported by rr_first.
    localparam int RR_MAX_REQ   = 32;
    localparam int RR_IDX_MAX_W = 5;

    typedef struct packed {
        logic                    valid;
        logic [RR_IDX_MAX_W-1:0] idx;
    } rr_res_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scan offsets from the highest down to zero so that the smallest offset
    // from ptr that has a request is the last one written, i.e. the winner.
    function automatic rr_res_t rr_first(input logic [RR_MAX_REQ-1:0] req,
                                         input int ptr,
                                         input int n);
        rr_res_t res;
        int      k;
        res = '0;
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                k = ptr + i;
                if (k >= n) begin
                    k = k - n;
                end
                if (req[k]) begin
                    res.valid = 1'b1;
                    res.idx   = k[RR_IDX_MAX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_wr_arb_rr_pick.sv
// rr_pick: combinational masked round-robin picker.
//   req    : raw request vector
//   mask   : requesters excluded from this pick
//   ptr    : index where the search starts (wraps at NUM_REQ-1 -> 0)
//   onehot : one-hot winner, all zero when nothing is eligible
//   idx    : winner index (don't care when valid=0)
//   valid  : at least one eligible request
module rr_pick
    import reg_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [RR_MAX_REQ-1:0] elig_ext;
    rr_res_t               res;

    always_comb begin
        elig_ext                = '0;
        elig_ext[NUM_REQ-1:0]   = req & ~mask;
        res                     = rr_first(elig_ext, int'(ptr), NUM_REQ);
    end

    assign valid = res.valid;
    assign idx   = res.idx[IDX_W-1:0];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign onehot[gi] = res.valid && (res.idx == RR_IDX_MAX_W'(gi));
    end

endmodule

// File: rtl/reg_wr_arb.sv
// reg_wr_arb: round-robin write arbiter in front of a shared register bank.
//   clk, rst          : clock, synchronous active-high reset
//   req/lock          : per-requester write and lock requests
//   addr/wdata        : packed per-requester write address / data
//   gnt               : registered one-hot grant pulse
//   wr_en/addr/data   : registered write port into the register bank
//   locked            : high on grants that belong to a locked burst
//   wait_max          : (only with REG_WR_ARB_STATS_EN) longest req-to-gnt wait
// Optional feature macro: REG_WR_ARB_STATS_EN.
module reg_wr_arb
    import reg_wr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        locked
`ifdef REG_WR_ARB_STATS_EN
    ,
    output logic [7:0]                  wait_max
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                locked_q, locked_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    logic [NUM_REQ-1:0]  owner_oh;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [IDX_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    // In IDLE the requester currently shown on gnt is masked so its held req
    // is not granted twice. In LOCKED only the owner is eligible, and it is
    // not masked: each cycle it holds req is another beat of the burst.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        if (state_q == LOCKED) begin
            pick_mask = ~owner_oh;
            pick_ptr  = owner_q;
        end else begin
            pick_mask = gnt_q;
            pick_ptr  = ptr_q;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        locked_d  = 1'b0;

        if (pick_valid) begin
            gnt_d     = pick_onehot;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_arr[pick_idx];
            wr_data_d = wdata_arr[pick_idx];
            ptr_d     = pick_idx + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid && lock[pick_idx]) begin
                    locked_d = 1'b1;
                    // A one-beat burst is already complete after this grant.
                    if (LOCK_MAX > 1) begin
                        state_d = LOCKED;
                        owner_d = pick_idx;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (!req[owner_q]) begin
                    // Owner went away: release without a grant this cycle.
                    state_d = IDLE;
                    cnt_d   = '0;
                    ptr_d   = owner_q + 1'b1;
                end else if (!lock[owner_q]) begin
                    // Final, unlocked write from the owner ends the burst.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    locked_d = 1'b1;
                    if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                        // This grant reaches LOCK_MAX; peers get the next turn.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            locked_q  <= locked_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign locked  = locked_q;

`ifdef REG_WR_ARB_STATS_EN
    // Per-requester wait counters count cycles of req without the matching
    // gnt on the output; they clear on the cycle gnt is shown.
    logic [7:0] wcnt_q [NUM_REQ];
    logic [7:0] wcnt_d [NUM_REQ];
    logic [7:0] wait_max_q, wait_max_d;

    always_comb begin
        wait_max_d = wait_max_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                wcnt_d[i] = '0;
            end else if (req[i] && (wcnt_q[i] != 8'hFF)) begin
                wcnt_d[i] = wcnt_q[i] + 8'd1;
            end else begin
                wcnt_d[i] = wcnt_q[i];
            end
            if (wcnt_q[i] > wait_max_d) begin
                wait_max_d = wcnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_max_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wcnt_q[i] <= '0;
            end
        end else begin
            wait_max_q <= wait_max_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wcnt_q[i] <= wcnt_d[i];
            end
        end
    end

    assign wait_max = wait_max_q;
`endif

endmodule
